// File: rtl/sdm_cic_decimator.sv
// sdm_cic_decimator: 4th-order CIC decimator turning 5-bit signed SDM codes into 24-bit signed PCM.
// Define SDM_DEC_SETTLE_EN to hide the first 4 partial-response outputs after reset.
module sdm_cic_decimator #(
  parameter int DEC_LOG2 = 7,
  parameter int ACC_W = 5 + 4 * DEC_LOG2
) (
  input  logic                clock,
  input  logic                rst,
  input  logic                clk_en,
  input  logic signed [4:0]   DataIn,
  output logic signed [23:0]  DataOut,
  output logic                DataValid
);
  localparam int SH = 4 * DEC_LOG2 - 19;
  logic signed [ACC_W-1:0] i1, i2, i3, i4;
  logic signed [ACC_W-1:0] c1, c2, c3, c4;
  logic signed [ACC_W-1:0] d1, d2, d3, d4;
  logic [DEC_LOG2-1:0] phase;
  logic s0, v1, v2, v3, v4;
  logic show;
`ifdef SDM_DEC_SETTLE_EN
  logic [2:0] settle;
  always_ff @(posedge clock) begin
    if (rst)
      settle <= '0;
    else if (v4 && settle != 3'd4)
      settle <= settle + 3'd1;
  end
  assign show = (settle == 3'd4);
`else
  assign show = 1'b1;
`endif
  // Integrators use pre-edge values of the previous stage; combs run on clock, gated by their valids.
  always_ff @(posedge clock) begin
    if (rst) begin
      {i1, i2, i3, i4} <= '0;
      {c1, c2, c3, c4} <= '0;
      {d1, d2, d3, d4} <= '0;
      phase <= '0;
      {s0, v1, v2, v3, v4} <= '0;
      DataOut <= '0;
      DataValid <= 1'b0;
    end else begin
      if (clk_en) begin
        i1 <= i1 + ACC_W'(DataIn);
        i2 <= i2 + i1;
        i3 <= i3 + i2;
        i4 <= i4 + i3;
        phase <= phase + 1'b1;
      end
      s0 <= clk_en && phase == '1;
      {v1, v2, v3, v4} <= {s0, v1, v2, v3};
      if (s0) begin
        c1 <= i4 - d1;
        d1 <= i4;
      end
      if (v1) begin
        c2 <= c1 - d2;
        d2 <= c1;
      end
      if (v2) begin
        c3 <= c2 - d3;
        d3 <= c2;
      end
      if (v3) begin
        c4 <= c3 - d4;
        d4 <= c3;
      end
      DataValid <= v4 && show;
      if (v4 && show)
        DataOut <= 24'(c4 >>> SH);
    end
  end
endmodule

// File: tb/tb_sdm_cic_decimator.sv
// tb_sdm_cic_decimator: directed checks of reset, DC gain, pulse timing, wrap and mid-frame reset.
module tb_sdm_cic_decimator;
  logic clock = 1'b0;
  logic rst = 1'b1;
  logic clk_en = 1'b0;
  logic signed [4:0] data_in = '0;
  logic signed [23:0] data_out;
  logic data_valid;
  int tests = 0;
  int fails = 0;
`ifdef SDM_DEC_SETTLE_EN
  localparam int SETTLE = 4;
`else
  localparam int SETTLE = 0;
`endif

  always #5 clock = ~clock;

  sdm_cic_decimator dut (
    .clock(clock),
    .rst(rst),
    .clk_en(clk_en),
    .DataIn(data_in),
    .DataOut(data_out),
    .DataValid(data_valid)
  );

  task automatic apply_reset();
    rst = 1'b1;
    clk_en = 1'b0;
    @(posedge clock);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      data_in = 5'($urandom);
      clk_en = 1'($urandom);
      @(posedge clock);
      #1;
      tests++;
      if (data_out !== 24'h0 || data_valid !== 1'b0) begin
        fails++;
        $display("FAIL reset_hold[%0d]: out=%h valid=%b, want out=000000 valid=0", i, data_out, data_valid);
      end
    end
    rst = 1'b0;
    clk_en = 1'b0;
    @(posedge clock);
    #1;
    tests++;
    if (data_out !== 24'h0 || data_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_release: out=%h valid=%b, want out=000000 valid=0", data_out, data_valid);
    end
  endtask

  // Constant (or alternating) input with clk_en every per-th cycle; checks pulse timing every cycle
  // and the settled output value from the 5th comb-output event onward.
  task automatic test_stream(input logic signed [4:0] v, input int per, input int n_out,
                             input logic [23:0] exp_out, input bit alt, input string name);
    int q = 0;
    int due = -1;
    int k = 0;
    apply_reset();
    for (int c = 1; k < n_out; c++) begin
      clk_en = ((c - 1) % per == 0);
      data_in = (alt && (q % 2 == 1)) ? -v : v;
      @(posedge clock);
      #1;
      if (clk_en) begin
        q++;
        if (q % 128 == 0) due = c + 5;
      end
      if (c == due) k++;
      tests++;
      if (data_valid !== (c == due && k > SETTLE)) begin
        fails++;
        $display("FAIL %s valid c=%0d: got %b want %b", name, c, data_valid, (c == due && k > SETTLE));
      end
      if (c == due && k >= 5) begin
        tests++;
        if (data_out !== exp_out) begin
          fails++;
          $display("FAIL %s out #%0d: got %h want %h", name, k, data_out, exp_out);
        end
      end
    end
    clk_en = 1'b0;
  endtask

  task automatic test_reset_mid_frame();
    int q = 0;
    int due = -1;
    int k = 0;
    apply_reset();
    data_in = 5'sd3;
    clk_en = 1'b1;
    // Edge 317 is the 61st edge of the third frame, so phase is 60 when rst hits.
    for (int c = 1; c <= 1100; c++) begin
      rst = (c == 317);
      @(posedge clock);
      #1;
      if (c == 317) begin
        q = 0;
        due = -1;
        k = 0;
        tests++;
        if (data_out !== 24'h0 || data_valid !== 1'b0) begin
          fails++;
          $display("FAIL midreset_clear: out=%h valid=%b, want 000000/0", data_out, data_valid);
        end
      end else begin
        q++;
        if (q % 128 == 0) due = c + 5;
      end
      if (c == due) k++;
      tests++;
      if (data_valid !== (c == due && k > SETTLE)) begin
        fails++;
        $display("FAIL midreset valid c=%0d: got %b want %b", c, data_valid, (c == due && k > SETTLE));
      end
      if (c == due && k >= 5) begin
        tests++;
        if (data_out !== 24'h180000) begin
          fails++;
          $display("FAIL midreset out #%0d: got %h want 180000", k, data_out);
        end
      end
    end
    rst = 1'b0;
    clk_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stream(5'sd3, 1, 7, 24'h180000, 1'b0, "dc_pos");
    test_stream(5'sd15, 1, 7, 24'h780000, 1'b0, "pos_full");
    test_stream(-5'sd16, 1, 22, 24'h800000, 1'b0, "neg_full");
    test_stream(5'sd1, 4, 7, 24'h080000, 1'b0, "sparse");
    test_stream(5'sd1, 1, 8, 24'h000000, 1'b1, "alternating");
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/sdm_cic_decimator.md
# sdm_cic_decimator

Fourth-order CIC decimator that turns the 5-bit signed oversampled sigma-delta stream back into 24-bit signed PCM at the base rate. It is the receive end of the DAC modulator interface. It is used for loopback verification of the digital DAC path and as the front end of the ADC decimation chain. Full-scale mapping matches the modulator feedback weighting: a code v corresponds to v·2^19 in 24-bit PCM.

## Interface
Parameters:
- DEC_LOG2, default 7: log2 of the decimation ratio R (R = 128 = OSR). Legal range is 5..8.
- ACC_W, default 5+4·DEC_LOG2 (33): width of the internal accumulators. Derived; do not override.

Ports:
- clock, input, 1: system clock.
- rst, input, 1: reset, **synchronous, active-high**.
- clk_en, input, 1: input sample strobe. DataIn is consumed only on edges where clk_en=1.
- DataIn, input, 5: signed modulator output code.
- DataOut, output, 24: signed decimated PCM sample.
- DataValid, output, 1: one-clock pulse marking a new DataOut.

## Operation
- **Integrators I1..I4** are ACC_W-bit signed and use modular (wrapping) two's-complement arithmetic. Wrap is required and must not saturate.
  - They update only on clk_en=1: I1+=sext(DataIn), I2+=I1, I3+=I2, I4+=I3.
  - Each stage uses the pre-edge value of the previous stage, giving a pipelined Hogenauer structure with 3 samples of extra delay.
  - With clk_en=0, all integrators and the phase counter hold.
- **Phase counter**, 0..R-1, advances on clk_en. On a clk_en edge with phase==R-1, phase wraps to 0 and the decimation strobe s0 is registered to 1.
- **Comb pipeline** has 4 stages, one per clock, and runs on clock rather than clk_en.
  - Stage k advances only when its input valid is high: ck <= in − dk, then dk <= in, and valid propagates.
  - Stage 1 input is I4.
  - Delay registers dk hold when the stage's valid is low.
- **Output scaling:** DataOut <= c4[ACC_W-1 : 4·DEC_LOG2−19]. This is exact, with no rounding, because the DC gain is 2^(4·DEC_LOG2). The extreme codes +15 and −16 fit without overflow.
- **Hold behaviour:** DataOut holds its value between pulses.
- **Settle counter** is 0..4 and saturating. It increments on each comb-output event. It is used only when SDM_DEC_SETTLE_EN is defined (see Configuration).
- **Reset (rst=1 at an edge):**
  - Cleared: all integrators, combs, delay registers, the phase counter, pipeline valids and the settle counter.
  - Outputs: DataOut=0, DataValid=0.
  - Reset mid-frame discards the partial frame, and any in-flight comb data is flushed.

## Timing
- **Decimation edge E0:** the clk_en edge with phase==R-1.
  - s0 is high after E0.
  - Comb stages register at E1..E4.
  - DataOut and DataValid register at E5, so DataValid is high for exactly the one cycle after E5.
- **Latency:** 5 clocks from E0 to DataValid, independent of clk_en spacing.
- **Pulse spacing:** DataValid pulses are separated by exactly R qualifying clk_en edges.
- **clk_en rate:** clk_en may be high every cycle. R≥32 guarantees the comb pipeline drains before the next strobe.
- **Overlaps:**
  - A clk_en edge coinciding with E1..E5 updates the integrators normally.
  - Comb stage 1 samples the post-E0 I4, because it reads I4 at E1 before the E1 update.
- **Deassertion of rst:** the first sample is taken on the first clk_en edge with rst=0.

## Configuration
- Macro: SDM_DEC_SETTLE_EN.
- **Defined:** DataValid and the DataOut update are suppressed for the first 4 comb-output events after reset, while the filter fills. The 5th event is the first visible output.
- **Undefined:** every comb-output event produces DataOut and DataValid, including the partial-response samples. The settle counter is not instantiated.

## Test plan
1. **Reset:** hold rst=1 for 3 clocks with random DataIn and clk_en → DataOut=0x000000, DataValid=0 throughout and on the first clock after release.
2. **Positive DC, clk_en every cycle:** DataIn=+3 constant from reset → DataValid every 128 clocks, each pulse 1 cycle wide. From the 5th output onward, DataOut=0x180000.
   - With SDM_DEC_SETTLE_EN defined, the first visible pulse is the 5th output event.
3. **Negative full scale:** DataIn=−16 constant → steady DataOut=0x800000, with no wrap artefact across ≥20 outputs, including integrator wraparound.
4. **Sparse strobe:** clk_en every 4th cycle, DataIn=+1 → DataValid period of 512 clocks, asserted exactly 5 clocks after the 128th qualifying edge. Steady DataOut=0x080000.
5. **Alternating input:** DataIn alternating +1/−1 at full clk_en rate (DC 0) → steady DataOut=0x000000.
6. **Reset mid-frame:** with DataIn=+3, assert rst for 1 clock at phase 60 → no DataValid for the aborted frame. The next pulse comes 5 clocks after the 128th post-reset qualifying edge, and the settle sequence restarts when the macro is defined.
